// File: rtl/tcm_boot_loader.sv
// Boot loader: parses a framed byte stream into ITCM/DTCM byte writes, then pulses cpu_start.
// Optional LOADER_CHECKSUM_EN: each section ends with a mod-256 payload checksum byte.
module tcm_boot_loader #(
    parameter int          ITCM_AW     = 12,
    parameter int          DTCM_AW     = 12,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               itcm_en,
    output logic [ITCM_AW-1:0] itcm_addr,
    output logic [7:0]         itcm_data,
    output logic               dtcm_en,
    output logic [DTCM_AW-1:0] dtcm_addr,
    output logic [7:0]         dtcm_data,
    output logic               cpu_start,
    output logic               busy,
    output logic               running,
    output logic               err,
    output logic [7:0]         sec_cnt
);
    localparam int PW = (ITCM_AW > DTCM_AW) ? ITCM_AW : DTCM_AW;

    localparam logic [3:0] S_CMD     = 4'd0;
    localparam logic [3:0] S_ADDR0   = 4'd1;
    localparam logic [3:0] S_ADDR1   = 4'd2;
    localparam logic [3:0] S_LEN0    = 4'd3;
    localparam logic [3:0] S_LEN1    = 4'd4;
    localparam logic [3:0] S_DATA    = 4'd5;
    localparam logic [3:0] S_RUN     = 4'd6;
    localparam logic [3:0] S_RUNNING = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CSUM    = 4'd9;
`endif

    logic [3:0]    state;
    logic          sel_itcm;
    logic [7:0]    addr_lo;
    logic [7:0]    len_lo;
    logic [PW-1:0] ptr;
    logic [15:0]   len_rem;
    logic [15:0]   len_full;
    logic [31:0]   tmo;
    logic          accept;
    logic          tmo_active;
    logic          tmo_hit;
    logic [7:0]    sec_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    always_comb begin
        in_ready   = 1'b0;
        tmo_active = 1'b0;
        case (state)
            S_CMD: in_ready = 1'b1;
            S_ADDR0, S_ADDR1, S_LEN0, S_LEN1, S_DATA: begin
                in_ready   = 1'b1;
                tmo_active = (TIMEOUT_CYC != 0);
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready   = 1'b1;
                tmo_active = (TIMEOUT_CYC != 0);
            end
`endif
            default: begin
                in_ready   = 1'b0;
                tmo_active = 1'b0;
            end
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign tmo_hit   = tmo_active && !accept && (tmo == 32'(TIMEOUT_CYC - 1));
    assign len_full  = {in_data, len_lo};
    assign sec_inc   = (sec_cnt == 8'hFF) ? 8'hFF : sec_cnt + 8'd1;
    assign busy      = !(state == S_CMD || state == S_RUNNING || state == S_ERR);
    assign running   = (state == S_RUNNING);
    assign err       = (state == S_ERR);
    assign cpu_start = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S_CMD;
            sel_itcm  <= 1'b0;
            addr_lo   <= '0;
            len_lo    <= '0;
            ptr       <= '0;
            len_rem   <= '0;
            tmo       <= '0;
            sec_cnt   <= '0;
            itcm_en   <= 1'b0;
            itcm_addr <= '0;
            itcm_data <= '0;
            dtcm_en   <= 1'b0;
            dtcm_addr <= '0;
            dtcm_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            itcm_en <= 1'b0;
            dtcm_en <= 1'b0;
            if (accept || !tmo_active) tmo <= '0;
            else                       tmo <= tmo + 32'd1;

            case (state)
                S_CMD: if (accept) begin
                    case (in_data)
                        8'hA5:   begin sel_itcm <= 1'b1; state <= S_ADDR0; end
                        8'h5A:   begin sel_itcm <= 1'b0; state <= S_ADDR0; end
                        8'hC3:   state <= S_RUN;
                        default: state <= S_ERR;
                    endcase
                end
                S_ADDR0: if (accept) begin
                    addr_lo <= in_data;
                    state   <= S_ADDR1;
                end
                S_ADDR1: if (accept) begin
                    // Upper address bits beyond the TCM width are dropped here.
                    ptr   <= PW'({in_data, addr_lo});
                    state <= S_LEN0;
                end
                S_LEN0: if (accept) begin
                    len_lo <= in_data;
                    state  <= S_LEN1;
                end
                S_LEN1: if (accept) begin
                    len_rem <= len_full;
`ifdef LOADER_CHECKSUM_EN
                    sum   <= '0;
                    state <= (len_full == 16'd0) ? S_CSUM : S_DATA;
`else
                    if (len_full == 16'd0) begin
                        sec_cnt <= sec_inc;
                        state   <= S_CMD;
                    end else begin
                        state <= S_DATA;
                    end
`endif
                end
                S_DATA: if (accept) begin
                    if (sel_itcm) begin
                        itcm_en   <= 1'b1;
                        itcm_addr <= ptr[ITCM_AW-1:0];
                        itcm_data <= in_data;
                    end else begin
                        dtcm_en   <= 1'b1;
                        dtcm_addr <= ptr[DTCM_AW-1:0];
                        dtcm_data <= in_data;
                    end
                    ptr     <= ptr + PW'(1);
                    len_rem <= len_rem - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum <= sum + in_data;
                    if (len_rem == 16'd1) state <= S_CSUM;
`else
                    if (len_rem == 16'd1) begin
                        sec_cnt <= sec_inc;
                        state   <= S_CMD;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (accept) begin
                    if (in_data == sum) begin
                        sec_cnt <= sec_inc;
                        state   <= S_CMD;
                    end else begin
                        state <= S_ERR;
                    end
                end
`endif
                S_RUN:   state <= S_RUNNING;
                default: ;
            endcase

            if (tmo_hit) state <= S_ERR;
        end
    end
endmodule

// File: tb/tb_tcm_boot_loader.sv
// Self-checking bench for tcm_boot_loader: randomized frames checked against a queue-based write model.
`timescale 1ns/1ps
module tb_tcm_boot_loader;
    localparam int          AW    = 12;
    localparam int unsigned AMASK = (1 << AW) - 1;

    logic clk = 1'b0, rst_ = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, itcm_en, dtcm_en, cpu_start, busy, running, err;
    logic [AW-1:0] itcm_addr, dtcm_addr;
    logic [7:0] itcm_data, dtcm_data, sec_cnt;

    logic in_valid2 = 1'b0;
    logic [7:0] in_data2 = 8'h00;
    logic in_ready2, itcm_en2, dtcm_en2, cpu_start2, busy2, running2, err2;
    logic [AW-1:0] itcm_addr2, dtcm_addr2;
    logic [7:0] itcm_data2, dtcm_data2, sec_cnt2;

    tcm_boot_loader #(.ITCM_AW(AW), .DTCM_AW(AW), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .itcm_en(itcm_en), .itcm_addr(itcm_addr), .itcm_data(itcm_data),
        .dtcm_en(dtcm_en), .dtcm_addr(dtcm_addr), .dtcm_data(dtcm_data),
        .cpu_start(cpu_start), .busy(busy), .running(running), .err(err), .sec_cnt(sec_cnt)
    );

    tcm_boot_loader #(.ITCM_AW(AW), .DTCM_AW(AW), .TIMEOUT_CYC(0)) dut_nt (
        .clk(clk), .rst_(rst_), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .itcm_en(itcm_en2), .itcm_addr(itcm_addr2), .itcm_data(itcm_data2),
        .dtcm_en(dtcm_en2), .dtcm_addr(dtcm_addr2), .dtcm_data(dtcm_data2),
        .cpu_start(cpu_start2), .busy(busy2), .running(running2), .err(err2), .sec_cnt(sec_cnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        itcm;
        logic [31:0] cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t act_q[$], exp_q[$];
    int  start_q[$];
    logic [7:0] pl[$];
    int  exp_sec = 0;
    int  vectors = 0;
    int  miscompares = 0;

    // Observed writes and start pulses, stamped with the cycle they are visible in.
    always @(negedge clk) begin
        wr_t w;
        if (itcm_en) begin
            w.itcm = 1'b1; w.cyc = cyc; w.addr = 16'(itcm_addr); w.data = itcm_data;
            act_q.push_back(w);
        end
        if (dtcm_en) begin
            w.itcm = 1'b0; w.cyc = cyc; w.addr = 16'(dtcm_addr); w.data = dtcm_data;
            act_q.push_back(w);
        end
        if (cpu_start) start_q.push_back(cyc);
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        bit done = 1'b0;
        idle(gap);
        in_valid = 1'b1;
        in_data  = b;
        acc      = -1;
        for (int t = 0; t < 32 && !done; t++) begin
            if (in_ready) begin
                acc  = cyc;
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_wait byte=%02h in_ready=%b required=1", b, in_ready);
        end
    endtask

    // Model: payload byte i lands at (base+i) mod 2^AW, visible the cycle after it is accepted.
    task automatic send_section(input bit it, input logic [15:0] base, input int gap_max,
                                input logic [7:0] csum_xor);
        int acc;
        logic [7:0] sum = 8'h00;
        logic [15:0] len = 16'(pl.size());
        wr_t w;
        send_byte(it ? 8'hA5 : 8'h5A, int'($urandom_range(gap_max, 0)), acc);
        send_byte(base[7:0],  int'($urandom_range(gap_max, 0)), acc);
        send_byte(base[15:8], int'($urandom_range(gap_max, 0)), acc);
        send_byte(len[7:0],   int'($urandom_range(gap_max, 0)), acc);
        send_byte(len[15:8],  int'($urandom_range(gap_max, 0)), acc);
        foreach (pl[i]) begin
            send_byte(pl[i], int'($urandom_range(gap_max, 0)), acc);
            w.itcm = it;
            w.cyc  = 32'(acc + 1);
            w.addr = 16'((32'(base) + 32'(i)) & AMASK);
            w.data = pl[i];
            exp_q.push_back(w);
            sum = sum + pl[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum ^ csum_xor, int'($urandom_range(gap_max, 0)), acc);
        if (csum_xor == 8'h00 && exp_sec < 255) exp_sec++;
`else
        if (csum_xor == 8'h00 && exp_sec < 255) exp_sec++;
`endif
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        rst_      = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        act_q.delete();
        exp_q.delete();
        start_q.delete();
        exp_sec = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if ({in_ready, busy, running, err, cpu_start, itcm_en, dtcm_en} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=1000000",
                     {in_ready, busy, running, err, cpu_start, itcm_en, dtcm_en});
        end
        vectors++;
        if ({sec_cnt, itcm_addr, dtcm_addr, itcm_data, dtcm_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_values sec=%h ia=%h da=%h id=%h dd=%h exp all 0",
                     sec_cnt, itcm_addr, dtcm_addr, itcm_data, dtcm_data);
        end
    endtask

    task automatic test_itcm();
        apply_reset();
        pl = '{8'h11, 8'h22, 8'h33};
        send_section(1'b1, 16'h0100, 0, 8'h00);
        idle(3);
        #1;
        vectors++;
        if (act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL itcm_count got=%0d exp=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL itcm_write[%0d] got it=%b cyc=%0d a=%h d=%h exp it=%b cyc=%0d a=%h d=%h", i,
                         act_q[i].itcm, act_q[i].cyc, act_q[i].addr, act_q[i].data,
                         exp_q[i].itcm, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (sec_cnt !== 8'(exp_sec) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL itcm_done sec=%0d busy=%b exp sec=%0d busy=0", sec_cnt, busy, exp_sec);
        end
    endtask

    task automatic test_dtcm_wrap();
        act_q.delete();
        exp_q.delete();
        pl = '{8'hAA, 8'hBB, 8'hCC};
        send_section(1'b0, 16'h0FFE, 0, 8'h00);
        pl = '{8'h01, 8'h02};
        send_section(1'b1, 16'hF7FF, 1, 8'h00);
        idle(3);
        #1;
        vectors++;
        if (act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL wrap_count got=%0d exp=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL wrap_write[%0d] got it=%b cyc=%0d a=%h d=%h exp it=%b cyc=%0d a=%h d=%h", i,
                         act_q[i].itcm, act_q[i].cyc, act_q[i].addr, act_q[i].data,
                         exp_q[i].itcm, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (sec_cnt !== 8'(exp_sec)) begin
            miscompares++;
            $display("FAIL wrap_sec got=%0d exp=%0d", sec_cnt, exp_sec);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        apply_reset();
        send_byte(8'hA5, 0, acc);
        send_byte(8'h20, 0, acc);
        send_byte(8'h03, 0, acc);
        send_byte(8'h04, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h01, 0, acc);
        send_byte(8'h02, 0, acc);
        #1;
        vectors++;
        if (itcm_en !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pending itcm_en=%b busy=%b exp 1 1", itcm_en, busy);
        end
        rst_ = 1'b0;
        #1;
        vectors++;
        if (itcm_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_async en=%b busy=%b rdy=%b exp 0 0 1", itcm_en, busy, in_ready);
        end
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (sec_cnt !== 8'h00 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after sec=%0d err=%b exp 0 0", sec_cnt, err);
        end
        act_q.delete();
        exp_q.delete();
        exp_sec = 0;
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            int n = int'($urandom_range(12, 0));
            pl.delete();
            for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
            send_section(1'($urandom_range(1, 0)), 16'($urandom), 3, 8'h00);
        end
        idle(3);
        #1;
        vectors++;
        if (act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count got=%0d exp=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_write[%0d] got it=%b cyc=%0d a=%h d=%h exp it=%b cyc=%0d a=%h d=%h", i,
                         act_q[i].itcm, act_q[i].cyc, act_q[i].addr, act_q[i].data,
                         exp_q[i].itcm, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        vectors++;
        if (sec_cnt !== 8'(exp_sec) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_sec got=%0d err=%b exp=%0d err=0", sec_cnt, err, exp_sec);
        end
    endtask

    task automatic test_sec_saturate();
        pl.delete();
        act_q.delete();
        for (int s = 0; s < 260; s++) send_section(1'($urandom_range(1, 0)), 16'($urandom), 0, 8'h00);
        idle(2);
        #1;
        vectors++;
        if (sec_cnt !== 8'd255 || act_q.size() != 0) begin
            miscompares++;
            $display("FAIL sec_saturate sec=%0d writes=%0d exp sec=255 writes=0", sec_cnt, act_q.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        apply_reset();
        pl = '{8'h10, 8'h20};
        send_section(1'b1, 16'h0000, 0, 8'h00);
        idle(1);
        #1;
        vectors++;
        if (sec_cnt !== 8'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL csum_ok sec=%0d err=%b exp 1 0", sec_cnt, err);
        end
        send_section(1'b1, 16'h0000, 0, 8'h01);
        idle(2);
        #1;
        vectors++;
        if (err !== 1'b1 || sec_cnt !== 8'd1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL csum_bad err=%b sec=%0d rdy=%b exp 1 1 0", err, sec_cnt, in_ready);
        end
        vectors++;
        if (act_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL csum_count got=%0d exp=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            vectors++;
            if (act_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL csum_write[%0d] got a=%h d=%h exp a=%h d=%h", i,
                         act_q[i].addr, act_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask
`endif

    task automatic test_run();
        int acc;
        apply_reset();
        pl.delete();
        send_section(1'b0, 16'h0000, 0, 8'h00);
        send_byte(8'hC3, 0, acc);
        idle(3);
        #1;
        vectors++;
        if (start_q.size() != 1 || (start_q.size() == 1 && start_q[0] != acc + 1)) begin
            miscompares++;
            $display("FAIL run_pulse count=%0d first=%0d exp count=1 cyc=%0d", start_q.size(),
                     (start_q.size() > 0) ? start_q[0] : -1, acc + 1);
        end
        vectors++;
        if ({running, in_ready, busy, cpu_start} !== 4'b1000 || sec_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL run_state run/rdy/busy/start=%b sec=%0d exp 1000 sec=1",
                     {running, in_ready, busy, cpu_start}, sec_cnt);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = (k == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (act_q.size() != 0 || start_q.size() != 1 || running !== 1'b1 || sec_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL run_locked writes=%0d starts=%0d run=%b sec=%0d exp 0 1 1 1",
                     act_q.size(), start_q.size(), running, sec_cnt);
        end
    endtask

    task automatic test_bad_cmd();
        apply_reset();
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        #1;
        vectors++;
        if ({err, in_ready, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL bad_cmd err/rdy/busy=%b exp 100", {err, in_ready, busy});
        end
        in_data = 8'hA5;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b1 || act_q.size() != 0 || sec_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL bad_sticky err=%b writes=%0d sec=%0d exp 1 0 0", err, act_q.size(), sec_cnt);
        end
        apply_reset();
        #1;
        vectors++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_reset err=%b rdy=%b exp 0 1", err, in_ready);
        end
    endtask

    task automatic test_timeout();
        int acc;
        apply_reset();
        send_byte(8'hA5, 0, acc);
        send_byte(8'h00, 0, acc);
        idle(7);
        #1;
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_early err=%b busy=%b exp 0 1", err, busy);
        end
        idle(1);
        #1;
        vectors++;
        if (err !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_hit err=%b rdy=%b exp 1 0", err, in_ready);
        end
        apply_reset();
        in_valid2 = 1'b1;
        in_data2  = 8'hA5;
        @(negedge clk);
        in_data2 = 8'h00;
        @(negedge clk);
        in_valid2 = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        vectors++;
        if (err2 !== 1'b0 || busy2 !== 1'b1 || in_ready2 !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_disabled err=%b busy=%b rdy=%b exp 0 1 1", err2, busy2, in_ready2);
        end
    endtask

    initial begin
        test_reset();
        test_itcm();
        test_dtcm_wrap();
        test_reset_mid();
        test_random();
        test_sec_saturate();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_run();
        test_bad_cmd();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
